gray_position_tracker: RTL and testbench
========================================

# gray_position_tracker

Consumes a W-bit Gray-coded position word, such as a rotary or linear encoder output or the output of the binary-to-Gray stage, that arrives asynchronously to the system clock. The block synchronizes the word, decodes it back to binary and classifies every change as an up step, a down step or an illegal jump. It accumulates a signed position count and a saturating error count. It sits directly downstream of the Gray encoder and feeds control logic with a clean binary position.

## Interface
- `W`, default 4: width of the Gray input and the decoded binary value; must be at least 2.
- `POS_W`, default 16: width of the position accumulator, two's complement.
- `clk` input, 1 bit: single system clock; all state changes on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `gray_in` input, W bits: asynchronous Gray-coded position; MSB is `gray_in[W-1]`.
- `clr` input, 1 bit: synchronous clear of `pos` and `err_cnt`.
- `bin_out` output, W bits: registered decoded binary value of the synchronized input.
- `pos` output, POS_W bits: signed accumulated position.
- `step_valid` output, 1 bit: one-cycle pulse when a legal ±1 step is accepted.
- `step_dir` output, 1 bit: direction of the last accepted step; 1 means up. Holds its value between steps.
- `err` output, 1 bit: one-cycle pulse on an illegal jump.
- `err_cnt` output, 8 bits: count of illegal jumps, saturating at 255.

## Operation
- **Synchronizer.** Two flops, `s1` then `s2`, sample `gray_in` on every edge. No logic is placed between them.
- **Decode of `s2`, combinational:**
  - `b[W-1] = s2[W-1]`
  - `b[i] = b[i+1] ^ s2[i]` for i from W-2 down to 0.
- **Delta.** `d = (b - bin_out) mod 2^W`, computed W bits wide.
- **State machine with two states:**
  - FILL, entered on reset. A 2-bit fill counter increments every edge. While in FILL, `bin_out` is loaded with `b` every edge, and `step_valid` and `err` stay 0. When the counter reaches 2, the block moves to TRACK, so exactly 3 edges are spent in FILL. No step or error is ever reported for the first sampled value.
  - TRACK, each edge, classified on `d`:
    - `d == 0`: no action.
    - `d == 1`: `pos <= pos + 1`, `step_valid <= 1`, `step_dir <= 1`.
    - `d == 2^W - 1`: `pos <= pos - 1`, `step_valid <= 1`, `step_dir <= 0`.
    - Any other value: `err <= 1`, `err_cnt` increments unless it already equals 255, `pos` is unchanged.
    - In every case `bin_out <= b`. The block resynchronizes to the new value after an error.
- **Wrap rules.**
  - The W-bit code wraps naturally. Binary 2^W-1 followed by binary 0 is an up step.
  - `pos` wraps modulo 2^POS_W: 0x7FFF + 1 gives 0x8000 for POS_W=16.
- **`clr` in TRACK.**
  - `pos` and `err_cnt` are set to 0 and override any increment or decrement in the same cycle.
  - `step_valid`, `step_dir`, `err` and `bin_out` still update normally.
- **`clr` in FILL.** Clears `pos` and `err_cnt`; no other effect.
- **Reset.**
  - Reset values: `s1=0`, `s2=0`, `bin_out=0`, `pos=0`, `step_valid=0`, `step_dir=0`, `err=0`, `err_cnt=0`; state is FILL and the fill counter is 0.
  - Reset asserted mid-operation takes effect immediately, without waiting for a clock edge. The FILL sequence repeats after release.

## Timing
- Input-to-output latency is 3 edges. For a value stable before edge E0: it is in `s1` after E0, in `s2` after E1, and `bin_out`, `pos`, `step_valid` and `err` reflect it after E2.
- `step_valid` and `err` are high for exactly one cycle per event. They are never high in the same cycle.
- Back-to-back legal steps, one new code per clock, produce consecutive `step_valid` pulses with no gaps.
- Multi-bit skew on `gray_in` across a sampling edge is tolerated only when the encoder changes one bit per transition.

## Test plan
- **Reset.** Assert `rst_n=0` with `gray_in=0101`, then release and run 4 edges. Required: all outputs 0 during reset; after FILL, `bin_out=0110`, `pos=0`, and no `step_valid` or `err` pulse.
- **Up sweep with wrap.** From `gray_in=0000`, apply Gray codes for binary 1..15 and then 0, one every 15 clocks. Required: 16 `step_valid` pulses, `step_dir=1`, `pos=16`, `err_cnt=0`, final `bin_out=0000`.
- **Down across wrap.** From binary 0, apply Gray 1000 (binary 15), then 1001 (binary 14). Required: 2 pulses with `step_dir=0` and `pos=-2`, i.e. 0xFFFE.
- **Illegal jump.** Apply Gray 0000, then 0011 (binary 2). Required: one `err` pulse, `pos` unchanged, `err_cnt=1`, `bin_out=0010`. Then apply 0010 (binary 3): `step_valid` pulses and `pos` increments by 1.
- **`clr` collision.** Assert `clr` in the same cycle an up step is decoded, with `pos=5`. Required: `pos=0`, `step_valid=1` that cycle, and `err_cnt=0`.
- **Saturation and mid-run reset.** Force 260 alternating illegal jumps. Required: `err_cnt` holds at 255. Then pulse `rst_n` low mid-sweep: all outputs return to 0 immediately and the FILL sequence repeats.

Source files
------------

// File: rtl/gray_position_tracker.sv
// Gray-coded position input: two-flop synchronizer, Gray-to-binary decode,
// up/down/illegal step classification, signed position and error counters.
module gray_position_tracker #(
  parameter int W     = 4,
  parameter int POS_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     gray_in,
  input  logic             clr,
  output logic [W-1:0]     bin_out,
  output logic [POS_W-1:0] pos,
  output logic             step_valid,
  output logic             step_dir,
  output logic             err,
  output logic [7:0]       err_cnt
);

  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] TRACK = 1'b1;

  localparam logic [W-1:0] D_UP = W'(1);
  localparam logic [W-1:0] D_DN = {W{1'b1}};

  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic [W-1:0] b;
  logic [W-1:0] d;
  logic [0:0]   state;
  logic [1:0]   fill_cnt;
  logic         is_up;
  logic         is_dn;
  logic         is_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= gray_in;
      s2 <= s1;
    end
  end

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    b = '0;
    for (int i = 0; i < W; i++) begin
      b[i] = ^(s2 >> i);
    end
  end

  assign d = b - bin_out;

  always_comb begin
    is_up  = 1'b0;
    is_dn  = 1'b0;
    is_bad = 1'b0;
    unique case (1'b1)
      (d == '0):   ;
      (d == D_UP): is_up = 1'b1;
      (d == D_DN): is_dn = 1'b1;
      default:     is_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      fill_cnt <= 2'd0;
    end else if (state == FILL) begin
      fill_cnt <= fill_cnt + 2'd1;
      if (fill_cnt == 2'd2) begin
        state <= TRACK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_out    <= '0;
      step_valid <= 1'b0;
      step_dir   <= 1'b0;
      err        <= 1'b0;
    end else begin
      bin_out    <= b;
      step_valid <= 1'b0;
      err        <= 1'b0;
      if (state == TRACK) begin
        step_valid <= is_up | is_dn;
        err        <= is_bad;
        if (is_up) begin
          step_dir <= 1'b1;
        end else if (is_dn) begin
          step_dir <= 1'b0;
        end
      end
    end
  end

  // clr wins over any same-cycle count update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos     <= '0;
      err_cnt <= 8'd0;
    end else if (clr) begin
      pos     <= '0;
      err_cnt <= 8'd0;
    end else if (state == TRACK) begin
      if (is_up) begin
        pos <= pos + POS_W'(1);
      end else if (is_dn) begin
        pos <= pos - POS_W'(1);
      end
      if (is_bad && err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_gray_position_tracker.sv
// Bench for gray_position_tracker: directed scenarios plus a random walk,
// all checked against a sample-history reference model.
module tb_gray_position_tracker;

  localparam int W  = 4;
  localparam int PW = 16;
  localparam int WM = (1 << W) - 1;
  localparam int PM = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic [W-1:0]  gray_in = '0;
  logic [W-1:0]  bin_out;
  logic [PW-1:0] pos;
  logic          step_valid;
  logic          step_dir;
  logic          err;
  logic [7:0]    err_cnt;

  gray_position_tracker #(.W(W), .POS_W(PW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gray_in    (gray_in),
    .clr        (clr),
    .bin_out    (bin_out),
    .pos        (pos),
    .step_valid (step_valid),
    .step_dir   (step_dir),
    .err        (err),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;

  int mq[$];
  int medge, mbin, mpos, msv, mdir, merr, mecnt;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int g2b(int g);
    int r = 0;
    for (int s = 0; s < W; s++) r ^= (g >> s);
    return r & WM;
  endfunction

  function automatic logic [W-1:0] b2g(int v);
    int m = v & WM;
    return W'(m ^ (m >> 1));
  endfunction

  task automatic model_reset();
    mq = '{0, 0};
    medge = 0; mbin = 0; mpos = 0;
    msv = 0; mdir = 0; merr = 0; mecnt = 0;
  endtask

  // What the DUT sees at an edge is the input sampled two edges earlier.
  task automatic model_edge();
    int v, bv, dd;
    v = mq.pop_front();
    mq.push_back(int'(gray_in));
    medge++;
    bv = g2b(v);
    msv = 0;
    merr = 0;
    if (medge > 3) begin
      dd = (bv - mbin) & WM;
      if (dd == 1) begin
        mpos++; msv = 1; mdir = 1;
      end else if (dd == WM) begin
        mpos--; msv = 1; mdir = 0;
      end else if (dd != 0) begin
        merr = 1;
        if (mecnt < 255) mecnt++;
      end
    end
    mbin = bv;
    if (clr) begin
      mpos = 0;
      mecnt = 0;
    end
    mpos &= PM;
  endtask

  task automatic check_all(string tag);
    check({tag, ".bin"}, 32'(bin_out), 32'(mbin));
    check({tag, ".pos"}, 32'(pos), 32'(mpos));
    check({tag, ".sv"}, 32'(step_valid), 32'(msv));
    check({tag, ".dir"}, 32'(step_dir), 32'(mdir));
    check({tag, ".err"}, 32'(err), 32'(merr));
    check({tag, ".ecnt"}, 32'(err_cnt), 32'(mecnt));
  endtask

  task automatic check_zero(string tag);
    check({tag, ".bin0"}, 32'(bin_out), 0);
    check({tag, ".pos0"}, 32'(pos), 0);
    check({tag, ".sv0"}, 32'(step_valid), 0);
    check({tag, ".dir0"}, 32'(step_dir), 0);
    check({tag, ".err0"}, 32'(err), 0);
    check({tag, ".ecnt0"}, 32'(err_cnt), 0);
  endtask

  task automatic cyc(string tag, int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      if (step_valid === 1'b1) pulses++;
      check_all(tag);
    end
  endtask

  task automatic do_clr(string tag);
    clr = 1'b1;
    cyc(tag);
    clr = 1'b0;
  endtask

  initial begin
    int cur;
    model_reset();
    gray_in = 4'b0101;
    #12;
    check_zero("rst");
    rst_n = 1'b1;
    cyc("fill", 4);
    check("rst_bin", 32'(bin_out), 32'h6);
    check("rst_pos", 32'(pos), 0);

    gray_in = '0;
    cyc("settle", 5);
    do_clr("clr0");
    pulses = 0;
    for (int v = 1; v <= 16; v++) begin
      gray_in = b2g(v);
      cyc("up", 15);
    end
    check("up_pulses", 32'(pulses), 16);
    check("up_pos", 32'(pos), 16);
    check("up_dir", 32'(step_dir), 1);
    check("up_bin", 32'(bin_out), 0);
    check("up_ecnt", 32'(err_cnt), 0);

    do_clr("clr1");
    gray_in = 4'b1000;
    cyc("dn", 5);
    gray_in = 4'b1001;
    cyc("dn", 5);
    check("dn_pos", 32'(pos), 32'hFFFE);
    check("dn_dir", 32'(step_dir), 0);

    gray_in = 4'b0000;
    cyc("ill", 5);
    do_clr("clr2");
    gray_in = 4'b0011;
    cyc("ill", 5);
    check("ill_ecnt", 32'(err_cnt), 1);
    check("ill_bin", 32'(bin_out), 2);
    check("ill_pos", 32'(pos), 0);
    gray_in = 4'b0010;
    cyc("ill", 5);
    check("ill_step", 32'(pos), 1);

    do_clr("clr3");
    cur = 3;
    for (int k = 0; k < 5; k++) begin
      cur++;
      gray_in = b2g(cur);
      cyc("col", 1);
    end
    cyc("col", 3);
    check("col_pre", 32'(pos), 5);
    cur++;
    gray_in = b2g(cur);
    cyc("col", 2);
    clr = 1'b1;
    cyc("col");
    clr = 1'b0;
    check("col_sv", 32'(step_valid), 1);
    check("col_pos", 32'(pos), 0);
    check("col_ecnt", 32'(err_cnt), 0);

    for (int k = 0; k < 260; k++) begin
      gray_in = b2g((k % 2) ? 0 : 8);
      cyc("sat");
    end
    cyc("sat", 3);
    check("sat_ecnt", 32'(err_cnt), 255);

    cur = g2b(int'(gray_in));
    for (int k = 0; k < 6; k++) begin
      cur++;
      gray_in = b2g(cur);
      cyc("mid");
    end
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    model_reset();
    #2;
    rst_n = 1'b1;
    cyc("refill", 4);

    for (int k = 0; k < 2000; k++) begin
      int r = $urandom_range(0, 99);
      if (r < 40) cur++;
      else if (r < 75) cur--;
      else if (r < 85) cur += $urandom_range(2, WM - 1);
      cur &= WM;
      gray_in = b2g(cur);
      clr = ($urandom_range(0, 49) == 0);
      cyc("rnd");
    end
    clr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
